// File: rtl/set_candidate_counter.sv
// Counts the lattice points of an 8x8 grid (x,y in 1..8) that meet a set relation
// among up to three circles. One point is scanned per cycle; the result comes out on a one-cycle valid strobe.
module set_candidate_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [23:0] central,
  input  logic [11:0] radius,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        valid,
  output logic [7:0]  candidate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [23:0] central_q;
  logic [11:0] radius_q;
  logic [1:0]  mode_q;
  logic [6:0]  idx;
  logic [6:0]  acc;
  logic [3:0]  px;
  logic [3:0]  py;
  logic        in_a;
  logic        in_b;
  logic        in_c;
  logic        hit;

  // The compare is inclusive. Differences can reach -14, so they are sign-extended before squaring.
  function automatic logic in_circle(input logic [3:0] ptx, input logic [3:0] pty,
                                     input logic [3:0] cx,  input logic [3:0] cy,
                                     input logic [3:0] r);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] d2;
    logic [7:0]         r2;
    dx = $signed({7'd0, ptx}) - $signed({7'd0, cx});
    dy = $signed({7'd0, pty}) - $signed({7'd0, cy});
    d2 = dx * dx + dy * dy;
    r2 = {4'd0, r} * {4'd0, r};
    return ($unsigned(d2) <= {3'd0, r2});
  endfunction

  assign px = {1'b0, idx[2:0]} + 4'd1;
  assign py = {1'b0, idx[5:3]} + 4'd1;

  // Membership of the current point and the set relation selected for the job.
  always_comb begin
    in_a = in_circle(px, py, central_q[23:20], central_q[19:16], radius_q[11:8]);
    in_b = in_circle(px, py, central_q[15:12], central_q[11:8],  radius_q[7:4]);
    in_c = in_circle(px, py, central_q[7:4],   central_q[3:0],   radius_q[3:0]);
    hit  = 1'b0;
    case (mode_q)
      2'b00:   hit = in_a;
      2'b01:   hit = in_a & in_b;
      2'b10:   hit = in_a ^ in_b;
      2'b11:   hit = ({1'b0, in_a} + {1'b0, in_b} + {1'b0, in_c}) == 2'd2;
      default: hit = 1'b0;
    endcase
  end

  // Next-state logic. idx reaching 64 means all points have been accumulated.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (en) state_next = CALC;
        else    state_next = IDLE;
      end
      CALC: begin
        if (idx == 7'd64) state_next = DONE;
        else              state_next = CALC;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Job latch, scan counter, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      central_q <= 24'd0;
      radius_q  <= 12'd0;
      mode_q    <= 2'd0;
      idx       <= 7'd0;
      acc       <= 7'd0;
      candidate <= 8'd0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      busy  <= (state_next != IDLE);
      valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (en) begin
            central_q <= central;
            radius_q  <= radius;
            mode_q    <= mode;
            idx       <= 7'd0;
            acc       <= 7'd0;
          end
        end
        CALC: begin
          if (idx != 7'd64) begin
            acc <= acc + {6'd0, hit};
            idx <= idx + 7'd1;
          end else begin
            candidate <= {1'b0, acc};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_set_candidate_counter.sv
// Directed bench for set_candidate_counter: a table of jobs with hand-computed counts,
// plus sequences for reset, en while busy, and a reset during a scan.
module tb_set_candidate_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [23:0] central = 24'd0;
  logic [11:0] radius = 12'd0;
  logic [1:0]  mode = 2'd0;
  logic        busy;
  logic        valid;
  logic [7:0]  candidate;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    int          expv;
  } vec_t;

  vec_t vecs [13];

  set_candidate_counter dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
    .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Starts a job, then scrambles the inputs. If pulse_at > 0, it pulses en with other inputs during CALC.
  task automatic run_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                         input int expv, input int pulse_at, input string nm);
    int lat;
    lat = -1;
    @(negedge clk);
    central = c; radius = r; mode = m; en = 1'b1;
    @(posedge clk); #1;
    chk({nm, "_busy_at_accept"}, int'(busy), 1);
    chk({nm, "_valid_at_accept"}, int'(valid), 0);
    en = 1'b0; central = ~c; radius = ~r; mode = ~m;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        break;
      end
      en = (k == pulse_at) ? 1'b1 : 1'b0;
    end
    en = 1'b0;
    chk({nm, "_latency"}, lat, 65);
    chk({nm, "_count"}, int'(candidate), expv);
    chk({nm, "_busy_in_done"}, int'(busy), 1);
    @(posedge clk); #1;
    chk({nm, "_valid_one_cycle"}, int'(valid), 0);
    chk({nm, "_busy_after"}, int'(busy), 0);
    chk({nm, "_count_held"}, int'(candidate), expv);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{24'h440000, 12'h000, 2'b00, 1};
    vecs[1]  = '{24'h440000, 12'h100, 2'b00, 5};
    vecs[2]  = '{24'h440000, 12'h200, 2'b00, 13};
    vecs[3]  = '{24'h110000, 12'hF00, 2'b00, 64};
    vecs[4]  = '{24'h112200, 12'h110, 2'b01, 2};
    vecs[5]  = '{24'h112200, 12'h110, 2'b10, 4};
    vecs[6]  = '{24'h444444, 12'h111, 2'b11, 0};
    vecs[7]  = '{24'h445488, 12'h110, 2'b11, 2};
    vecs[8]  = '{24'h444488, 12'h000, 2'b11, 1};
    vecs[9]  = '{24'h000000, 12'h200, 2'b00, 1};
    vecs[10] = '{24'h444400, 12'h110, 2'b10, 0};
    vecs[11] = '{24'h440000, 12'h300, 2'b00, 29};
    vecs[12] = '{24'h444500, 12'h100, 2'b01, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_candidate", int'(candidate), 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_busy", int'(busy), 0);
      chk("idle_valid", int'(valid), 0);
      chk("idle_candidate", int'(candidate), 0);
    end

    for (int i = 0; i < 13; i++)
      run_job(vecs[i].central, vecs[i].radius, vecs[i].mode, vecs[i].expv, 0,
              $sformatf("vec%0d", i));

    // An en pulse during CALC with different inputs must neither restart the job nor change its result.
    run_job(24'h440000, 12'h200, 2'b00, 13, 10, "en_while_busy");
    run_job(24'h110000, 12'hF00, 2'b00, 64, 40, "en_while_busy2");

    // A reset during the scan aborts the job; en in that same cycle is ignored.
    @(negedge clk);
    central = 24'h440000; radius = 12'h100; mode = 2'b00; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("mid_busy_before_rst", int'(busy), 1);
    rst = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_valid", int'(valid), 0);
    chk("rst_mid_candidate", int'(candidate), 0);
    rst = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    chk("rst_en_ignored", int'(busy), 0);
    run_job(24'h440000, 12'h100, 2'b00, 5, 0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
